// File: rtl/alu_result_fifo_pkg.sv
// Shared constants and entry type for the ALU result FIFO.
// ALU_RESULT_FIFO_PARITY_EN widens each entry by one even-parity bit.
package alu_result_fifo_pkg;

    localparam int unsigned DefaultWidth = 4;
    localparam int unsigned DefaultDepth = 4;
    localparam int unsigned PtrW         = $clog2(DefaultDepth);
    localparam int unsigned CntW         = PtrW + 1;

`ifdef ALU_RESULT_FIFO_PARITY_EN
    localparam int unsigned ParBits = 1;
`else
    localparam int unsigned ParBits = 0;
`endif

    localparam int unsigned EntryW = DefaultWidth + ParBits;

    typedef logic [EntryW-1:0] entry_t;

endpackage

// File: rtl/alu_result_fifo_if.sv
// Valid/ready result bus between the ALU output stage, the FIFO and its consumer.
interface alu_result_fifo_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [CntW-1:0]  count;
    logic             overflow;
    logic             out_parity;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count, overflow, out_parity
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count, overflow, out_parity
    );

endinterface

// File: rtl/alu_result_fifo_mem.sv
// Unreset register array: one synchronous write port, one asynchronous read port.
module alu_result_fifo_mem #(
    parameter int unsigned Width = 4,
    parameter int unsigned Depth = 4
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(Depth)-1:0] waddr_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic [$clog2(Depth)-1:0] raddr_i,
    output logic [Width-1:0]         rdata_o
);
    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];

    always_comb begin
        mem_d = mem_q;
        if (we_i) begin
            mem_d[waddr_i] = wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/alu_result_fifo.sv
// Circular register FIFO buffering ALU results; drops and flags results when full.
// ALU_RESULT_FIFO_PARITY_EN stores an even-parity bit per entry and drives out_parity.
module alu_result_fifo
    import alu_result_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned DEPTH = DefaultDepth
) (
    input logic              clk,
    input logic              reset,
    input logic              clr,
    alu_result_fifo_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned EW = WIDTH + ParBits;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          in_ready, out_valid, push, pop;
    logic [EW-1:0] wr_entry, rd_entry;

    // Handshake decoded from registered count only: no out_ready -> in_ready path.
    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = bus.in_valid && in_ready;
    assign pop       = out_valid && bus.out_ready;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (clr) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (bus.in_valid && !in_ready) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef ALU_RESULT_FIFO_PARITY_EN
    assign wr_entry       = {^bus.in_data, bus.in_data};
    assign bus.out_parity = out_valid ? rd_entry[WIDTH] : 1'b0;
`else
    assign wr_entry       = bus.in_data;
    assign bus.out_parity = 1'b0;
`endif

    alu_result_fifo_mem #(
        .Width (EW),
        .Depth (DEPTH)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (push && !clr),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_valid ? rd_entry[WIDTH-1:0] : '0;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Randomized bench for alu_result_fifo against a queue-based reference model.
// Parity expectations follow ALU_RESULT_FIFO_PARITY_EN.
module tb_alu_result_fifo;
    localparam int unsigned W = 4;
    localparam int unsigned D = 4;

    logic clk = 1'b0;
    logic reset;
    logic clr;

    alu_result_fifo_if #(.WIDTH(W), .DEPTH(D)) bus ();

    alu_result_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [W-1:0] model_q[$];
    logic         model_ovf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string where);
        logic [W-1:0] head;
        logic         par;
        head = (model_q.size() > 0) ? model_q[0] : '0;
`ifdef ALU_RESULT_FIFO_PARITY_EN
        par = (model_q.size() > 0) ? ^head : 1'b0;
`else
        par = 1'b0;
`endif
        check({where, ".count"},     32'(bus.count),     32'(model_q.size()));
        check({where, ".in_ready"},  32'(bus.in_ready),  32'(model_q.size() < D));
        check({where, ".out_valid"}, 32'(bus.out_valid), 32'(model_q.size() > 0));
        check({where, ".out_data"},  32'(bus.out_data),  32'(head));
        check({where, ".overflow"},  32'(bus.overflow),  32'(model_ovf));
        check({where, ".parity"},    32'(bus.out_parity), 32'(par));
    endtask

    // One clock: drive inputs, predict from pre-edge model state, sample #1 after the edge.
    task automatic cycle(input string where, input logic iv, input logic [W-1:0] id,
                         input logic ordy, input logic c);
        bit do_push, do_pop, do_drop;
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.out_ready = ordy;
        clr           = c;
        do_push = iv && (model_q.size() < D);
        do_drop = iv && (model_q.size() == D);
        do_pop  = ordy && (model_q.size() > 0);
        @(posedge clk);
        if (c) begin
            model_q.delete();
            model_ovf = 1'b0;
        end else begin
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back(id);
            if (do_drop) model_ovf = 1'b1;
        end
        #1;
        check_all(where);
    endtask

    initial begin
        logic [W-1:0] fill [4];
        fill[0] = 4'h3; fill[1] = 4'h5; fill[2] = 4'hF; fill[3] = 4'h8;
        reset = 1'b1;
        clr = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        model_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1 check_all("reset");

        for (int i = 0; i < 4; i++) cycle("fill", 1'b1, fill[i], 1'b0, 1'b0);
        cycle("drop", 1'b1, 4'hA, 1'b0, 1'b0);
        cycle("drop2", 1'b1, 4'hA, 1'b0, 1'b0);
        // Full + pop: incoming result still dropped.
        cycle("fullpop", 1'b1, 4'hA, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle("drain", 1'b0, 4'h0, 1'b1, 1'b0);
        cycle("refill", 1'b1, 4'h1, 1'b0, 1'b0);
        cycle("refill", 1'b1, 4'h2, 1'b0, 1'b0);
        cycle("clr", 1'b1, 4'h9, 1'b1, 1'b1);

        cycle("pre2", 1'b1, 4'hC, 1'b0, 1'b0);
        cycle("pre2", 1'b1, 4'hD, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle("pp2", 1'b1, W'($urandom), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle("drain2", 1'b0, 4'h0, 1'b1, 1'b0);

        for (int i = 0; i < 3; i++) cycle("pre_rst", 1'b1, W'(i + 7), 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        #2 reset = 1'b1;
        model_q.delete();
        model_ovf = 1'b0;
        #1 check_all("async_rst");
        @(posedge clk);
        #1 reset = 1'b0;
        cycle("push6", 1'b1, 4'h6, 1'b0, 1'b0);
        check("push6.data", 32'(bus.out_data), 32'h6);
        cycle("pop6", 1'b0, 4'h0, 1'b1, 1'b0);

        cycle("par7", 1'b1, 4'h7, 1'b0, 1'b0);
        cycle("par3", 1'b1, 4'h3, 1'b1, 1'b0);
        cycle("par_pop", 1'b0, 4'h0, 1'b1, 1'b0);

        for (int i = 0; i < 400; i++) begin
            cycle("rand", 1'($urandom_range(0, 3) != 0), W'($urandom),
                  1'($urandom_range(0, 2) == 0 ? 0 : $urandom_range(0, 1)),
                  1'($urandom_range(0, 63) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
